// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and its controlling FSM.
// The controller drives the master side; the sequencer sits on the slave side.
interface stage_sequencer_if #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned DWELL_W    = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
);
  logic                  start;
  logic                  advance;
  logic                  abort;
  logic                  loop_en;
  logic [DWELL_W-1:0]    dwell;
  logic [NUM_STAGES-1:0] stage;
  logic [IDX_W-1:0]      stage_idx;
  logic                  busy;
  logic                  done;
  logic                  wrap;

  modport master (
    output start, advance, abort, loop_en, dwell,
    input  stage, stage_idx, busy, done, wrap
  );

  modport slave (
    input  start, advance, abort, loop_en, dwell,
    output stage, stage_idx, busy, done, wrap
  );
endinterface

// File: rtl/stage_sequencer.sv
// One-hot stage sequencer: walks a token through NUM_STAGES enables on qualified
// advance strobes, with per-stage dwell, optional looping and abort.
module stage_sequencer #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned DWELL_W    = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic               clk,
  input  logic               rst_n,
  stage_sequencer_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap_q, wrap_d;
  logic [DWELL_W-1:0]    cnt_q, cnt_d;
  logic [DWELL_W-1:0]    dwell_cap_q, dwell_cap_d;
  logic                  loop_cap_q, loop_cap_d;

  logic dwell_hit;
  logic last_stage;
  logic stage_exit;

  assign dwell_hit  = (cnt_q == dwell_cap_q);
  assign last_stage = stage_q[NUM_STAGES-1];
  assign stage_exit = (state_q == StRun) && bus.advance && dwell_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort dominates everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.abort && bus.start) state_d = StRun;
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (stage_exit && last_stage && !loop_cap_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs and datapath next values
  always_comb begin
    stage_d     = stage_q;
    stage_idx_d = stage_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    cnt_d       = cnt_q;
    dwell_cap_d = dwell_cap_q;
    loop_cap_d  = loop_cap_q;

    if (bus.abort) begin
      stage_d     = '0;
      stage_idx_d = '0;
      busy_d      = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            dwell_cap_d = bus.dwell;
            loop_cap_d  = bus.loop_en;
            stage_d     = NUM_STAGES'(1);
            stage_idx_d = '0;
            busy_d      = 1'b1;
            cnt_d       = '0;
          end
        end
        StRun: begin
          if (bus.advance) begin
            if (!dwell_hit) begin
              cnt_d = cnt_q + DWELL_W'(1);
            end else begin
              cnt_d = '0;
              if (!last_stage) begin
                stage_d     = {stage_q[NUM_STAGES-2:0], 1'b0};
                stage_idx_d = stage_idx_q + IDX_W'(1);
              end else if (loop_cap_q) begin
                stage_d     = NUM_STAGES'(1);
                stage_idx_d = '0;
                wrap_d      = 1'b1;
              end else begin
                stage_d     = '0;
                stage_idx_d = '0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
              end
            end
          end
        end
        default: begin
          stage_d     = '0;
          stage_idx_d = '0;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stage_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
      dwell_cap_q <= '0;
      loop_cap_q  <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      stage_idx_q <= stage_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
      dwell_cap_q <= dwell_cap_d;
      loop_cap_q  <= loop_cap_d;
    end
  end

  assign bus.stage     = stage_q;
  assign bus.stage_idx = stage_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: a strobe-counting reference model pushes
// expected outputs per edge; a negedge monitor pops and compares.
module tb_stage_sequencer;
  localparam int NS = 6;
  localparam int DW = 4;
  localparam int IW = 3;

  typedef struct {
    logic [NS-1:0] stage;
    logic [IW-1:0] idx;
    logic          busy;
    logic          done;
    logic          wrap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];

  // Reference model: a pass is a count of advance strobes since start
  bit   m_run;
  int   m_cnt;
  int   m_dw;
  bit   m_lp;
  bit   m_done_now;

  stage_sequencer_if #(.NUM_STAGES(NS), .DWELL_W(DW), .IDX_W(IW)) bus ();

  stage_sequencer #(.NUM_STAGES(NS), .DWELL_W(DW), .IDX_W(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stage", int'(bus.stage), int'(e.stage));
      chk("stage_idx", int'(bus.stage_idx), int'(e.idx));
      chk("busy", int'(bus.busy), int'(e.busy));
      chk("done", int'(bus.done), int'(e.done));
      chk("wrap", int'(bus.wrap), int'(e.wrap));
      chk("onehot", int'($countones(bus.stage)), bus.busy ? 1 : 0);
    end
  end

  task automatic model_reset();
    m_run      = 1'b0;
    m_cnt      = 0;
    m_dw       = 0;
    m_lp       = 1'b0;
    m_done_now = 1'b0;
  endtask

  // Apply inputs for one edge, advance the model, push expectation after the edge
  task automatic step(input bit st, input bit adv, input bit ab, input bit le,
                      input int dw);
    exp_t e;
    int   k;
    bus.start   = st;
    bus.advance = adv;
    bus.abort   = ab;
    bus.loop_en = le;
    bus.dwell   = DW'(dw);
    e.done = 1'b0;
    e.wrap = 1'b0;
    if (ab) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1'b1;
        m_cnt = 0;
        m_dw  = dw;
        m_lp  = le;
      end
    end else if (adv) begin
      m_cnt++;
      if (m_cnt == NS * (m_dw + 1)) begin
        if (m_lp) begin
          m_cnt  = 0;
          e.wrap = 1'b1;
        end else begin
          m_run  = 1'b0;
          e.done = 1'b1;
        end
      end
    end
    k       = m_run ? m_cnt / (m_dw + 1) : 0;
    e.idx   = IW'(k);
    e.stage = m_run ? NS'(1) << k : '0;
    e.busy  = m_run;
    m_done_now = e.done;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    bus.start   = 1'b0;
    bus.advance = 1'b0;
    bus.abort   = 1'b0;
    bus.loop_en = 1'b0;
    bus.dwell   = '0;
    rst_n = 1'b0;
    #22;
    chk("rst_stage", int'(bus.stage), 0);
    chk("rst_idx", int'(bus.stage_idx), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    rst_n = 1'b1;
    #1;

    // Single fast pass, start on the first edge after reset release
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Dwell 2 with toggling advance; dwell/loop_en inputs change mid-run
    step(1'b1, 1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 42; i++) begin
      step(1'b0, (i % 2) == 0, 1'b0, i > 5, (i > 5) ? 9 : 2);
    end

    // Loop mode then abort
    step(1'b1, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle_cycles(2);

    // Abort with advance at last stage while dwell expires
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle_cycles(2);

    // Ignored restart at stage 2, then start in the done cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3);
    for (int i = 0; i < 12; i++) step(m_done_now, 1'b1, 1'b0, 1'b0, 1);
    idle_cycles(2);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Asynchronous reset at stage 3, between clock edges
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("pre_rst_idx", int'(bus.stage_idx), 3);
    rst_n = 1'b0;
    #1;
    chk("arst_stage", int'(bus.stage), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_idx", int'(bus.stage_idx), 0);
    @(posedge clk);
    #1;
    chk("arst_done", int'(bus.done), 0);
    chk("arst_wrap", int'(bus.wrap), 0);
    model_reset();
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
